// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory (slave).
interface data_mem_responder_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output MEM_R_EN, MEM_W_EN, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, addr, wdata,
        output rdata, stall, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering MEM-stage loads/stores with LATENCY wait states.
// Optional DMEM_CHECK_EN: flags misaligned/out-of-range accesses, suppresses them and pulses err.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic                  clk,
    input logic                  rstn,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx_c;
    logic             req_c, done_c, bad_c, we_c, rd_c;

    assign idx_c = bus.addr[IDX_W+1:2];
    assign req_c = bus.MEM_R_EN | bus.MEM_W_EN;

`ifdef DMEM_CHECK_EN
    logic err_q;

    assign bad_c = (bus.addr[1:0] != 2'b00) || (bus.addr[31:IDX_W+2] != '0);

    // One-cycle pulse following the completion edge of an erroring access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= done_c & bad_c;
    end

    assign bus.err = err_q;
`else
    logic unused_addr_c;

    assign bad_c         = 1'b0;
    assign unused_addr_c = ^{bus.addr[1:0], bus.addr[31:IDX_W+2]};
    assign bus.err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Wait-state sequencing; done_c marks the completion cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req_c) begin
                    if (LATENCY == 0) begin
                        done_c = 1'b1;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!req_c) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd0) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Store wins when both enables are set
    assign we_c = done_c & bus.MEM_W_EN & ~bad_c;
    assign rd_c = done_c & bus.MEM_R_EN & ~bus.MEM_W_EN & ~bad_c;

    // Array is intentionally not reset
    always_ff @(posedge clk) begin
        if (we_c) mem[idx_c] <= bus.wdata;
    end

    assign bus.stall = rstn & req_c & ~done_c;
    assign bus.rdata = (rstn & rd_c) ? mem[idx_c] : 32'd0;
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that answers the pipeline's MEM-stage load/store requests and returns the read value consumed by the MEM/WB pipeline register. It is the responder side of the MEM-stage memory interface. It inserts a parameterised number of wait states, signalled with `stall`, so the pipeline can be exercised against slow memory. Reads are combinational in the completion cycle, so MEM/WB captures `rdata` on the same edge the access completes. Writes commit on that edge.

## Interface
- `DEPTH`, 256: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: wait states per access, 0–15; 0 means single-cycle access with no stall.
- `clk`  input  1  — the single clock.
- `rstn`  input  1  — asynchronous, active-low reset.
- `MEM_R_EN`  input  1  — load request; held stable by the initiator while `stall`=1.
- `MEM_W_EN`  input  1  — store request; held stable by the initiator while `stall`=1.
- `addr`  input  32  — byte address; the word index is `addr[log2(DEPTH)+1:2]`.
- `wdata`  input  32  — store data.
- `rdata`  output  32  — load data, valid in the completion cycle; 0 otherwise.
- `stall`  output  1  — 1 while the access is not yet complete; the pipeline freezes.
- `err`  output  1  — registered one-cycle error pulse (only with `DMEM_CHECK_EN`).

## Operation
- A request is present when `MEM_R_EN | MEM_W_EN`. If both are asserted, the access is treated as a store and `rdata` is 0.
- FSM has two states: IDLE and BUSY, plus a 4-bit wait counter `cnt`.
- IDLE, no request: `stall`=0, `rdata`=0.
- IDLE, request, `LATENCY`=0: the access completes in this cycle.
  - `stall`=0.
  - Load: `rdata` = mem[idx].
  - Store: write at the clock edge.
- IDLE, request, `LATENCY`=L>0:
  - `stall`=1.
  - At the edge: go to BUSY with `cnt` = L-1.
- BUSY, request still present:
  - `cnt`≠0: `stall`=1, decrement `cnt` at the edge.
  - `cnt`=0: this is the completion cycle. `stall`=0, load data is driven on `rdata`, a store writes at the edge, then return to IDLE.
- BUSY, request withdrawn (both enables 0): abort. Go to IDLE at the next edge, `stall`=0, no write.
- After completion the FSM is in IDLE. If the pipeline presents another request next cycle, a new access starts; back-to-back requests each pay the full latency.
- Address bits above the index are ignored (aliasing wrap) unless `DMEM_CHECK_EN` is defined.
- The memory array is not reset; contents survive `rstn`.

## Timing
- Reset values while `rstn`=0:
  - state = IDLE, `cnt`=0, `err`=0.
  - `stall` is forced 0 and `rdata` is forced 0 regardless of inputs.
- Reset asserted mid-BUSY: the FSM returns to IDLE immediately (asynchronously), the pending store is discarded, and the array is unchanged.
- Access latency: L+1 cycles from the first request cycle to the completion edge, with exactly L cycles of `stall`=1.
- `stall` and `rdata` are combinational from state, `cnt` and the inputs. `err` is registered and asserted for the one cycle after the completion edge.
- A store followed by a load to the same address in the next request returns the new data.

## Configuration
- `DMEM_CHECK_EN` defined: an access is in error when `addr[1:0]`≠0 or when `addr` ≥ DEPTH*4. On an erroring access:
  - the normal wait states are still taken;
  - at completion the store is suppressed and `rdata`=0;
  - `err` pulses high for one cycle after the completion edge.
- `DMEM_CHECK_EN` undefined:
  - `err` is tied to 0;
  - `addr[1:0]` is ignored;
  - upper address bits alias into the array.

## Test plan
- Reset: hold `rstn`=0 with `MEM_R_EN`=1 → `stall`=0, `rdata`=0, `err`=0. Release reset → FSM starts in IDLE.
- `LATENCY`=2: store 0xDEADBEEF to 0x10, then load 0x10 → each access shows `stall`=1,1,0; the load's completion cycle shows `rdata`=0xDEADBEEF.
- `LATENCY`=0: store 0x12345678 to 0x20 and load 0x20 in consecutive cycles → `stall` never asserts; the load returns 0x12345678 in its request cycle.
- Abort: with `LATENCY`=3, start a store of 0xAAAA5555 to 0x40 and drop both enables after 1 BUSY cycle → next cycle is IDLE with `stall`=0; a later load of 0x40 returns the old value.
- Async reset mid-BUSY: with `LATENCY`=4, pulse `rstn` low during the second stall cycle of a store → `stall` drops in the same cycle, the array is unchanged, and a new request afterwards takes a full 4 stall cycles.
- `DMEM_CHECK_EN`: store to 0x13, then load from DEPTH*4 → both take full latency, neither write occurs, and `err`=1 for one cycle after each completion with `rdata`=0. Without the macro, the load from DEPTH*4 returns mem[0].
